// File: rtl/keypad_pkg.sv
// Shared types, key codes and helper functions for the 4x4 keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  // Codes for the non-digit keys; digits use their own value.
  localparam logic [3:0] KEY_A    = 4'hA;
  localparam logic [3:0] KEY_B    = 4'hB;
  localparam logic [3:0] KEY_C    = 4'hC;
  localparam logic [3:0] KEY_D    = 4'hD;
  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  // Row-sample value meaning "no row pulled low".
  localparam logic [3:0] ROWS_IDLE = 4'hF;

  // Physical position (row, column) to key code.
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    case ({row, col})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = KEY_A;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = KEY_B;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = KEY_C;
      4'b11_00: code = KEY_STAR;
      4'b11_01: code = 4'h0;
      4'b11_10: code = KEY_HASH;
      default:  code = KEY_D;
    endcase
    return code;
  endfunction

  // Lowest-index row that is pulled low (active-low row sample).
  function automatic logic [1:0] lowest_low_row(input logic [3:0] rows);
    logic [1:0] idx;
    if (!rows[0])      idx = 2'd0;
    else if (!rows[1]) idx = 2'd1;
    else if (!rows[2]) idx = 2'd2;
    else               idx = 2'd3;
    return idx;
  endfunction

endpackage

// File: rtl/keypad_sync.sv
// Two-flop synchronizer for the asynchronous keypad row inputs; resets to all-ones (idle rows).
module keypad_sync #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_reg;
  logic [WIDTH-1:0] sync_reg;

  // First stage may go metastable; second stage gives it a full cycle to resolve.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_reg <= '1;
      sync_reg <= '1;
    end else begin
      meta_reg <= d;
      sync_reg <= meta_reg;
    end
  end

  assign q = sync_reg;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column ring, settle timer, debounce FSM and the keypress/rdy handshake.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 16,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] keypress,
  output logic       rdy,
  output logic       key_held
);

  localparam int SW = $clog2(SCAN_DIV);
  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST    = DW'(DEBOUNCE_CYCLES - 1);

  logic [3:0]    rs;

  state_t        state_reg,    state_next;
  logic [1:0]    col_reg,      col_next;
  logic [SW-1:0] settle_reg,   settle_next;
  logic [DW-1:0] deb_reg,      deb_next;
  logic [3:0]    cand_reg,     cand_next;
  logic [3:0]    keypress_reg, keypress_next;
  logic          rdy_reg,      rdy_next;
  logic          held_reg,     held_next;

  keypad_sync #(.WIDTH(4)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (row_n),
    .q     (rs)
  );

  // Exactly one column driven low: the one selected by the ring index.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_col
      assign col_n[gi] = (col_reg != 2'(gi));
    end
  endgenerate

  // Next-state and next-output logic for the scan/debounce/press/release sequence.
  always_comb begin
    state_next    = state_reg;
    col_next      = col_reg;
    settle_next   = settle_reg;
    deb_next      = deb_reg;
    cand_next     = cand_reg;
    keypress_next = keypress_reg;
    rdy_next      = 1'b0;
    held_next     = held_reg;

    case (state_reg)
      SCAN: begin
        if (settle_reg == SETTLE_LAST) begin
          settle_next = '0;
          if (rs == ROWS_IDLE) begin
            col_next = col_reg + 2'd1;
          end else begin
            cand_next  = rs;
            deb_next   = '0;
            state_next = DEBOUNCE;
          end
        end else begin
          settle_next = settle_reg + 1'b1;
        end
      end

      DEBOUNCE: begin
        if (rs == ROWS_IDLE) begin
          // Bounce back to idle: resume scanning on the same column.
          settle_next = '0;
          deb_next    = '0;
          state_next  = SCAN;
        end else if (rs != cand_reg) begin
          cand_next = rs;
          deb_next  = '0;
        end else if (deb_reg == DEB_LAST) begin
          deb_next   = '0;
          state_next = PRESSED;
        end else begin
          deb_next = deb_reg + 1'b1;
        end
      end

      PRESSED: begin
        // Outputs are registered, so rdy/keypress appear on the cycle after PRESSED.
        rdy_next      = 1'b1;
        keypress_next = key_map(lowest_low_row(cand_reg), col_reg);
        held_next     = 1'b1;
        deb_next      = '0;
        state_next    = RELEASE;
      end

      RELEASE: begin
        if (rs == ROWS_IDLE) begin
          if (deb_reg == DEB_LAST) begin
            held_next   = 1'b0;
            col_next    = col_reg + 2'd1;
            settle_next = '0;
            deb_next    = '0;
            state_next  = SCAN;
          end else begin
            deb_next = deb_reg + 1'b1;
          end
        end else begin
          deb_next = '0;
        end
      end

      default: begin
        state_next = SCAN;
      end
    endcase
  end

  // State and output registers; reset overrides everything, including a pending rdy.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg    <= SCAN;
      col_reg      <= 2'd0;
      settle_reg   <= '0;
      deb_reg      <= '0;
      cand_reg     <= ROWS_IDLE;
      keypress_reg <= 4'h0;
      rdy_reg      <= 1'b0;
      held_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      col_reg      <= col_next;
      settle_reg   <= settle_next;
      deb_reg      <= deb_next;
      cand_reg     <= cand_next;
      keypress_reg <= keypress_next;
      rdy_reg      <= rdy_next;
      held_reg     <= held_next;
    end
  end

  assign keypress = keypress_reg;
  assign rdy      = rdy_reg;
  assign key_held = held_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Scoreboard bench for keypad_scanner: keypad matrix model, directed and random presses.
module tb_keypad_scanner;

  logic       clk;
  logic       reset;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] keypress;
  logic       rdy;
  logic       key_held;

  // key_down[r][c] = key at row r, column c is physically pressed
  logic [3:0][3:0] key_down;

  // Key codes, row-major (index r*4+c), straight from the keypad legend.
  logic [3:0] code_tab [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                4'h4, 4'h5, 4'h6, 4'hB,
                                4'h7, 4'h8, 4'h9, 4'hC,
                                4'hE, 4'h0, 4'hF, 4'hD};

  logic [3:0] exp_q [$];
  int checks;
  int fails;

  bit         mon_en;
  logic       rdy_prev;
  logic [3:0] kp_prev;
  logic       reset_prev;
  logic [3:0] exp_code;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
    .clk      (clk),
    .reset    (reset),
    .row_n    (row_n),
    .col_n    (col_n),
    .keypress (keypress),
    .rdy      (rdy),
    .key_held (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Keypad matrix: a row is pulled low if any pressed key on it sits in a driven column.
  always_comb begin
    row_n = 4'hF;
    for (int r = 0; r < 4; r++) row_n[r] = ~|(key_down[r] & ~col_n);
  end

  function automatic void chk(string name, logic [31:0] got, logic [31:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end else begin
      $display("ok   %s: %0h", name, got);
    end
  endfunction

  // Monitor: every rdy pops one expected code; keypress must not move outside rdy.
  always @(negedge clk) begin
    if (mon_en) begin
      if (rdy === 1'b1) begin
        chk("rdy_not_back_to_back", {31'd0, rdy_prev}, 32'd0);
        if (exp_q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_rdy: keypress %0h, no press pending", keypress);
        end else begin
          exp_code = exp_q.pop_front();
          chk("keypress_at_rdy", {28'd0, keypress}, {28'd0, exp_code});
          chk("key_held_at_rdy", {31'd0, key_held}, 32'd1);
        end
      end else if (reset === 1'b0 && reset_prev === 1'b0 && keypress !== kp_prev) begin
        chk("keypress_stable", {28'd0, keypress}, {28'd0, kp_prev});
      end
    end
    rdy_prev   <= rdy;
    kp_prev    <= keypress;
    reset_prev <= reset;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // After keys are released: key_held must drop (bounded), then all expected rdys consumed.
  task automatic finish_txn(input string name);
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (key_held === 1'b0) break;
    end
    chk({name, "_held_drops"}, (k < 200) ? 32'd1 : 32'd0, 32'd1);
    tick(6);
    chk({name, "_no_missing_rdy"}, exp_q.size(), 32'd0);
  endtask

  task automatic check_reset_outputs(input string name);
    chk({name, "_col_n"},    {28'd0, col_n},    32'hE);
    chk({name, "_keypress"}, {28'd0, keypress}, 32'h0);
    chk({name, "_rdy"},      {31'd0, rdy},      32'd0);
    chk({name, "_key_held"}, {31'd0, key_held}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    int c;
    int lo;
    logic [3:0] mask;
    checks   = 0;
    fails    = 0;
    mon_en   = 1'b0;
    reset    = 1'b1;
    key_down = '0;

    // 1: reset state, then idle column rotation every 4 clocks
    tick(3);
    @(negedge clk);
    check_reset_outputs("reset");
    tick(1);
    reset  = 1'b0;
    mon_en = 1'b1;
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      chk($sformatf("rotate_%0d", i), {28'd0, col_n}, {28'd0, ~(4'b0001 << ((i / 4) % 4))});
    end
    tick(1);

    // 2: clean press r2/c2 -> 9; release debounce latency
    key_down[2][2] = 1'b1;
    exp_q.push_back(code_tab[2*4+2]);
    tick(60);
    key_down = '0;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (key_held === 1'b0) break;
    end
    chk("release_latency_in_8_to_12", (k >= 8 && k <= 12) ? 32'd1 : 32'd0, 32'd1);
    tick(6);
    chk("t2_no_missing_rdy", exp_q.size(), 32'd0);

    // 3: bouncing press r2/c1 -> single 8
    exp_q.push_back(code_tab[2*4+1]);
    key_down[2][1] = 1'b1; tick(2);
    key_down[2][1] = 1'b0; tick(2);
    key_down[2][1] = 1'b1; tick(80);
    key_down = '0;
    finish_txn("t3");

    // 4: long hold r0/c0, short release glitch, then r3/c1
    exp_q.push_back(code_tab[0]);
    key_down[0][0] = 1'b1; tick(1000);
    key_down[0][0] = 1'b0; tick(3);
    key_down[0][0] = 1'b1; tick(50);
    key_down = '0;
    finish_txn("t4_hold");
    exp_q.push_back(code_tab[3*4+1]);
    key_down[3][1] = 1'b1; tick(80);
    key_down = '0;
    finish_txn("t4_zero");

    // 5: two rows in one column, plus a key in another column during the hold
    exp_q.push_back(code_tab[1*4+1]);
    key_down[1][1] = 1'b1;
    key_down[2][1] = 1'b1;
    tick(60);
    key_down[0][3] = 1'b1; tick(40);
    key_down[0][3] = 1'b0; tick(5);
    key_down = '0;
    finish_txn("t5");

    // Random presses: one or more rows in a random column; lowest row wins
    for (int t = 0; t < 8; t++) begin
      c    = $urandom_range(0, 3);
      mask = 4'($urandom_range(1, 15));
      lo   = 3;
      for (int r = 3; r >= 0; r--) if (mask[r]) lo = r;
      for (int r = 0; r < 4; r++) key_down[r][c] = mask[r];
      exp_q.push_back(code_tab[lo*4+c]);
      tick($urandom_range(50, 150));
      key_down = '0;
      finish_txn($sformatf("rand%0d", t));
      tick($urandom_range(0, 20));
    end

    // 6: measure reset-release-to-rdy time for r0/c0, then reset into DEBOUNCE and into PRESSED
    reset = 1'b1; tick(3);
    key_down[0][0] = 1'b1;
    exp_q.push_back(code_tab[0]);
    reset = 1'b0;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (rdy === 1'b1) break;
    end
    chk("measure_rdy_seen", (n < 100) ? 32'd1 : 32'd0, 32'd1);
    tick(1);
    key_down = '0;
    finish_txn("measure");
    if (n >= 6 && n < 100) begin
      for (int v = 0; v < 2; v++) begin
        reset = 1'b1; tick(3);
        key_down[0][0] = 1'b1;
        reset = 1'b0;
        repeat ((v == 0) ? n - 5 : n - 1) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs(v == 0 ? "rst_debounce" : "rst_pressed");
        key_down = '0;
        tick(3);
        reset = 1'b0;
        tick(40);
        chk(v == 0 ? "rst_debounce_no_rdy" : "rst_pressed_no_rdy", exp_q.size(), 32'd0);
      end
    end

    tick(10);
    chk("final_queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
